hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the five-stage MIPS datapath, replacing the fixed-width hazard unit. Combines memory-wait freezing, load-use bubble insertion, and taken-branch/jump flushing of a configurable number of stages. Adds a one-cycle dmem request drop after `dhit` and a saturating stall counter for performance measurement. Sits between the control unit, the pipeline latch enables/flushes, and the cache request lines.

---
 rtl/hazard_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// ----------------------------------------------------------------------------
// Pipeline hazard controller for the five-stage MIPS datapath.
//
// It combines three jobs:
//   * freezing the whole pipeline while a data-cache request is outstanding,
//   * inserting a bubble for read-after-write hazards that forwarding cannot
//     cover,
//   * flushing the younger stages on a taken branch or a decoded jump.
// It also drops the dmem request for one cycle after a dhit, so a request
// that has already been served is not issued again. A saturating counter
// records how many cycles the PC was held.
//
// Parameters
//   REG_W       register index width
//   FLUSH_DEPTH stages cleared on a taken branch (1..3)
//                 1 = IF/ID, 2 = IF/ID + ID/EX, 3 = also EX/MEM
//   CNT_W       stall counter width
//
// Ports
//   CLK, nRST                 clock, synchronous active-low reset
//   ihit, dhit                instruction / data cache hits
//   dmemREN_in, dmemWEN_in    memory request from the EX/MEM stage
//   branch_taken              branch resolved taken in EX/MEM
//   jump_id                   jump decoded in ID
//   ifid_rs, ifid_rt          source registers of the instruction in ID
//   idex_rd, idex_regwen,
//   idex_dmemREN              destination / write / load of the EX stage
//   exmem_rd, exmem_regwen    destination / write of the MEM stage
//   pcen .. memwb_en          pipeline latch enables
//   ifid_flush .. exmem_flush synchronous latch clears
//   imemREN, dmemREN, dmemWEN gated cache requests
//   stall_cnt                 cycles with pcen = 0, saturating
//
// Build option
//   HAZARD_FORWARD_EN  defined   : a forwarding unit exists, only load-use
//                                  hazards stall.
//                      undefined : every RAW hazard against EX or MEM stalls.
// ============================================================================
module hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN_in,
    input  logic             dmemWEN_in,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             idex_regwen,
    input  logic             idex_dmemREN,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic             exmem_regwen,
    output logic             pcen,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DWAIT = 2'd1;
    localparam logic [1:0] DDONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Which latches a taken branch clears, fixed at elaboration.
    localparam logic FLUSH_IDEX  = (FLUSH_DEPTH >= 2);
    localparam logic FLUSH_EXMEM = (FLUSH_DEPTH >= 3);

    logic [1:0] state;
    logic [1:0] next_state;
    logic       mem_req;
    logic       freeze;
    logic       ex_match;
    logic       mem_match;
    logic       raw_stall;

    assign mem_req = dmemREN_in | dmemWEN_in;

    // The pipeline is frozen whenever a memory access is waiting on the cache.
    // In DWAIT the request is by definition still outstanding until dhit.
    assign freeze = !dhit && (((state == RUN) && mem_req) || (state == DWAIT));

    // Source register in ID is produced by the instruction now in EX / MEM.
    // Register zero is never a real dependency.
    assign ex_match  = idex_regwen && (idex_rd != '0) &&
                       ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
    assign mem_match = exmem_regwen && (exmem_rd != '0) &&
                       ((exmem_rd == ifid_rs) || (exmem_rd == ifid_rt));

`ifdef HAZARD_FORWARD_EN
    // Forwarding covers everything except a load whose data is not back yet.
    logic unused_mem_match;
    assign unused_mem_match = mem_match;
    assign raw_stall        = ex_match && idex_dmemREN;
`else
    // No forwarding: any producer still in EX or MEM forces a stall.
    logic unused_idex_load;
    assign unused_idex_load = idex_dmemREN;
    assign raw_stall        = ex_match || mem_match;
`endif

    // Memory-wait sequencing: RUN issues, DWAIT holds until dhit, DDONE is
    // the single cycle in which the served request is masked off.
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (mem_req) begin
                    next_state = dhit ? DDONE : DWAIT;
                end
            end
            DWAIT: begin
                if (dhit) begin
                    next_state = DDONE;
                end
            end
            DDONE:   next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // State register; reset always lands in RUN, so a request that was in
    // flight when reset hit is simply abandoned.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Latch control. A memory freeze overrides everything; otherwise the
    // priority is branch, jump, data hazard, instruction miss.
    always_comb begin
        pcen        = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        imemREN     = 1'b1;
        dmemREN     = dmemREN_in;
        dmemWEN     = dmemWEN_in;

        if (!nRST) begin
            pcen        = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            imemREN     = 1'b0;
            dmemREN     = 1'b0;
            dmemWEN     = 1'b0;
        end else if (freeze) begin
            pcen     = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else begin
            // The request visible in DDONE was already served by the dhit.
            if (state == DDONE) begin
                dmemREN = 1'b0;
                dmemWEN = 1'b0;
            end

            if (branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = FLUSH_IDEX;
                exmem_flush = FLUSH_EXMEM;
            end else if (jump_id) begin
                ifid_flush = 1'b1;
            end else if (raw_stall) begin
                // Hold the dependent instruction in ID, send a bubble into EX.
                pcen       = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!ihit) begin
                // No valid fetch: keep the PC and feed a bubble into ID.
                pcen       = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    // Performance counter of PC-hold cycles; sticks at all-ones.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (!pcen && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl
// ----------------------------------------------------------------------------
// Directed bench for hazard_ctrl. Two instances share the same inputs:
//   dut  : default parameters (FLUSH_DEPTH = 2, CNT_W = 16)
//   dut3 : FLUSH_DEPTH = 3, CNT_W = 4 (shows the deeper flush and saturation)
// Enables are grouped as {pcen, ifid_en, idex_en, exmem_en, memwb_en},
// flushes as {ifid, idex, exmem}, requests as {imemREN, dmemREN, dmemWEN}.
// ============================================================================
module tb_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, dmemREN_in, dmemWEN_in, branch_taken, jump_id;
    logic [4:0] ifid_rs, ifid_rt, idex_rd, exmem_rd;
    logic       idex_regwen, idex_dmemREN, exmem_regwen;

    logic        pcen, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic        imemREN, dmemREN, dmemWEN;
    logic [15:0] stall_cnt;

    logic        pcen3, ifid_en3, idex_en3, exmem_en3, memwb_en3;
    logic        ifid_flush3, idex_flush3, exmem_flush3;
    logic        imemREN3, dmemREN3, dmemWEN3;
    logic [3:0]  stall_cnt3;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_cnt  = '0;
    logic [3:0]  exp_cnt3 = '0;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [4:0] RAW_EN = FWD ? 5'b11111 : 5'b00111;
    localparam logic [2:0] RAW_FL = FWD ? 3'b000   : 3'b010;

    always #5 CLK = ~CLK;

    hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dmemREN_in(dmemREN_in), .dmemWEN_in(dmemWEN_in),
        .branch_taken(branch_taken), .jump_id(jump_id),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_rd(idex_rd), .idex_regwen(idex_regwen), .idex_dmemREN(idex_dmemREN),
        .exmem_rd(exmem_rd), .exmem_regwen(exmem_regwen),
        .pcen(pcen), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.REG_W(5), .FLUSH_DEPTH(3), .CNT_W(4)) dut3 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dmemREN_in(dmemREN_in), .dmemWEN_in(dmemWEN_in),
        .branch_taken(branch_taken), .jump_id(jump_id),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_rd(idex_rd), .idex_regwen(idex_regwen), .idex_dmemREN(idex_dmemREN),
        .exmem_rd(exmem_rd), .exmem_regwen(exmem_regwen),
        .pcen(pcen3), .ifid_en(ifid_en3), .idex_en(idex_en3),
        .exmem_en(exmem_en3), .memwb_en(memwb_en3),
        .ifid_flush(ifid_flush3), .idex_flush(idex_flush3), .exmem_flush(exmem_flush3),
        .imemREN(imemREN3), .dmemREN(dmemREN3), .dmemWEN(dmemWEN3),
        .stall_cnt(stall_cnt3)
    );

    // Single comparison point; every failure is counted and reported.
    task automatic checkOutput(input string tag, input logic [15:0] obs,
                               input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive every DUT input for the coming cycle.
    task automatic applyStimulus(input logic n, input logic ih, input logic dh,
                                 input logic ren, input logic wen,
                                 input logic br, input logic jp,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] idrd, input logic idw,
                                 input logic idl, input logic [4:0] exrd,
                                 input logic exw);
        nRST = n; ihit = ih; dhit = dh; dmemREN_in = ren; dmemWEN_in = wen;
        branch_taken = br; jump_id = jp; ifid_rs = rs; ifid_rt = rt;
        idex_rd = idrd; idex_regwen = idw; idex_dmemREN = idl;
        exmem_rd = exrd; exmem_regwen = exw;
    endtask

    // Check combinational outputs, clock once, update the counter model,
    // then check both counters. Called just after a falling edge.
    task automatic stepCycle(input string tag, input logic [4:0] en,
                             input logic [2:0] fl2, input logic [2:0] fl3,
                             input logic [2:0] rq);
        #1;
        checkOutput({tag, "/en"},  {11'b0, pcen, ifid_en, idex_en, exmem_en, memwb_en}, {11'b0, en});
        checkOutput({tag, "/en3"}, {11'b0, pcen3, ifid_en3, idex_en3, exmem_en3, memwb_en3}, {11'b0, en});
        checkOutput({tag, "/fl"},  {13'b0, ifid_flush, idex_flush, exmem_flush}, {13'b0, fl2});
        checkOutput({tag, "/fl3"}, {13'b0, ifid_flush3, idex_flush3, exmem_flush3}, {13'b0, fl3});
        checkOutput({tag, "/rq"},  {13'b0, imemREN, dmemREN, dmemWEN}, {13'b0, rq});
        @(posedge CLK);
        if (!nRST) begin
            exp_cnt  = '0;
            exp_cnt3 = '0;
        end else if (!en[4]) begin
            if (exp_cnt  != 16'hFFFF) exp_cnt  = exp_cnt + 16'd1;
            if (exp_cnt3 != 4'hF)     exp_cnt3 = exp_cnt3 + 4'd1;
        end
        #1;
        checkOutput({tag, "/cnt"},  stall_cnt, exp_cnt);
        checkOutput({tag, "/cnt3"}, {12'b0, stall_cnt3}, {12'b0, exp_cnt3});
        @(negedge CLK);
    endtask

    // Directed sequence; each line gives inputs then the hand-derived outputs.
    initial begin
        $display("[TB] hazard_ctrl directed test start (forwarding=%0d)", FWD);
        applyStimulus(0,1,0,0,0,0,0, 0,0, 0,0,0, 0,0);
        @(negedge CLK);

        // Reset held for two cycles.
        applyStimulus(0,1,0,0,0,0,0, 0,0, 0,0,0, 0,0);
        stepCycle("rst1", 5'b00000, 3'b111, 3'b111, 3'b000);
        stepCycle("rst2", 5'b00000, 3'b111, 3'b111, 3'b000);

        // Release, fetch hitting.
        applyStimulus(1,1,0,0,0,0,0, 0,0, 0,0,0, 0,0);
        stepCycle("run", 5'b11111, 3'b000, 3'b000, 3'b100);

        // lw $2 in EX, add $3,$2,$4 in ID: one bubble.
        applyStimulus(1,1,0,0,0,0,0, 2,4, 2,1,1, 0,0);
        stepCycle("loaduse", 5'b00111, 3'b010, 3'b010, 3'b100);
        applyStimulus(1,1,0,0,0,0,0, 2,4, 0,0,0, 0,0);
        stepCycle("loaduse_clear", 5'b11111, 3'b000, 3'b000, 3'b100);

        // sw missing for three cycles, then hit, then DDONE drop.
        applyStimulus(1,1,0,0,1,0,0, 0,0, 0,0,0, 0,0);
        stepCycle("sw_wait1", 5'b00000, 3'b000, 3'b000, 3'b101);
        stepCycle("sw_wait2", 5'b00000, 3'b000, 3'b000, 3'b101);
        stepCycle("sw_wait3", 5'b00000, 3'b000, 3'b000, 3'b101);
        applyStimulus(1,1,1,0,1,0,0, 0,0, 0,0,0, 0,0);
        stepCycle("sw_hit", 5'b11111, 3'b000, 3'b000, 3'b101);
        applyStimulus(1,1,0,0,1,0,0, 0,0, 0,0,0, 0,0);
        stepCycle("sw_ddone", 5'b11111, 3'b000, 3'b000, 3'b100);

        // Taken branch: depth 2 vs depth 3.
        applyStimulus(1,1,0,0,0,1,0, 0,0, 0,0,0, 0,0);
        stepCycle("branch", 5'b11111, 3'b110, 3'b111, 3'b100);

        // Branch during a data miss: freeze first, flush on DDONE.
        applyStimulus(1,1,0,1,0,1,0, 0,0, 0,0,0, 0,0);
        stepCycle("br_freeze", 5'b00000, 3'b000, 3'b000, 3'b110);
        applyStimulus(1,1,1,1,0,1,0, 0,0, 0,0,0, 0,0);
        stepCycle("br_dhit", 5'b11111, 3'b110, 3'b111, 3'b110);
        applyStimulus(1,1,0,1,0,1,0, 0,0, 0,0,0, 0,0);
        stepCycle("br_ddone", 5'b11111, 3'b110, 3'b111, 3'b100);

        // Jump alone, and jump losing to branch.
        applyStimulus(1,1,0,0,0,0,1, 0,0, 0,0,0, 0,0);
        stepCycle("jump", 5'b11111, 3'b100, 3'b100, 3'b100);
        applyStimulus(1,1,0,0,0,1,1, 0,0, 0,0,0, 0,0);
        stepCycle("jump_br", 5'b11111, 3'b110, 3'b111, 3'b100);

        // Instruction miss, and load-use outranking it.
        applyStimulus(1,0,0,0,0,0,0, 0,0, 0,0,0, 0,0);
        stepCycle("imiss", 5'b01111, 3'b100, 3'b100, 3'b100);
        applyStimulus(1,0,0,0,0,0,0, 2,0, 2,1,1, 0,0);
        stepCycle("lu_imiss", 5'b00111, 3'b010, 3'b010, 3'b100);

        // RAW without a load: stalls only when forwarding is absent.
        applyStimulus(1,1,0,0,0,0,0, 5,0, 0,0,0, 5,1);
        stepCycle("raw_mem", RAW_EN, RAW_FL, RAW_FL, 3'b100);
        applyStimulus(1,1,0,0,0,0,0, 0,3, 3,1,0, 0,0);
        stepCycle("raw_ex", RAW_EN, RAW_FL, RAW_FL, 3'b100);

        // Register zero never creates a dependency.
        applyStimulus(1,1,0,0,0,0,0, 0,0, 0,1,1, 0,1);
        stepCycle("rd_zero", 5'b11111, 3'b000, 3'b000, 3'b100);

        // Reset in the middle of a data wait goes back to RUN.
        applyStimulus(1,1,0,1,0,0,0, 0,0, 0,0,0, 0,0);
        stepCycle("dwait_enter", 5'b00000, 3'b000, 3'b000, 3'b110);
        applyStimulus(0,1,0,1,0,0,0, 0,0, 0,0,0, 0,0);
        stepCycle("dwait_rst", 5'b00000, 3'b111, 3'b111, 3'b000);
        applyStimulus(1,1,0,0,0,0,0, 0,0, 0,0,0, 0,0);
        stepCycle("after_rst", 5'b11111, 3'b000, 3'b000, 3'b100);

        // Twenty miss cycles saturate the 4-bit counter.
        applyStimulus(1,0,0,0,0,0,0, 0,0, 0,0,0, 0,0);
        for (int i = 0; i < 20; i++) begin
            stepCycle("sat", 5'b01111, 3'b100, 3'b100, 3'b100);
        end
        checkOutput("sat_final3", {12'b0, stall_cnt3}, 16'd15);
        checkOutput("sat_final",  stall_cnt, 16'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
